// File: rtl/amdc_leds_pwm.sv
// AXI4-Lite LED controller: NUM_LEDS PWM/blink channels on a shared prescaled timebase.
// Channel settings are shadowed at PWM period boundaries so duty changes never glitch.
module amdc_leds_pwm #(
    parameter int NUM_LEDS           = 4,
    parameter int PWM_BITS           = 8,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_LEDS-1:0]             LED
);
    localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int NWORDS = 2 ** IDX_W;
    localparam int NBYTES = C_S_AXI_DATA_WIDTH / 8;

    logic                r_awready, r_bvalid, r_arready, r_rvalid;
    logic [31:0]         r_rdata;
    logic                r_en;
    logic [15:0]         r_prescale, r_half;
    logic [15:0]         r_pre_cnt, r_blink_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                r_blink_phase;

    logic [31:0]         w_words   [NWORDS];
    logic [31:0]         w_ch_word [NUM_LEDS];
    logic [IDX_W-1:0]    w_aw_idx, w_ar_idx;
    logic [31:0]         w_wmask, w_wr_word;
    logic                w_wr, w_rd, w_tick, w_boundary;
    logic                w_unused;

    assign w_aw_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_wr     = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
    assign w_rd     = r_arready & S_AXI_ARVALID;
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_awready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RDATA   = r_rdata;

    // Full readback map; unmapped words are constant zero.
    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
        if (gi == 0) begin : g_ctrl
            assign w_words[gi] = {r_prescale, 15'd0, r_en};
        end else if (gi == 1) begin : g_blink
            assign w_words[gi] = {16'd0, r_half};
        end else if (gi < NUM_LEDS + 2) begin : g_chan
            assign w_words[gi] = w_ch_word[gi-2];
        end else begin : g_none
            assign w_words[gi] = 32'd0;
        end
    end

    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_mask
        assign w_wmask[8*gi +: 8] = {8{S_AXI_WSTRB[gi]}};
    end
    assign w_wr_word = (w_words[w_aw_idx] & ~w_wmask) | (S_AXI_WDATA & w_wmask);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            r_awready <= S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid && !r_awready;
            if (w_wr)
                r_bvalid <= 1'b1;
            else if (S_AXI_BREADY)
                r_bvalid <= 1'b0;
            r_arready <= S_AXI_ARVALID && !r_rvalid && !r_arready;
            if (w_rd) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_words[w_ar_idx];
            end else if (S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_en       <= 1'b0;
            r_prescale <= 16'd0;
            r_half     <= 16'd0;
        end else if (w_wr) begin
            if (w_aw_idx == IDX_W'(0)) begin
                r_en       <= w_wr_word[0];
                r_prescale <= w_wr_word[31:16];
            end
            if (w_aw_idx == IDX_W'(1))
                r_half <= w_wr_word[15:0];
        end
    end

    assign w_tick     = r_en && (r_pre_cnt == r_prescale);
    assign w_boundary = w_tick && (r_pwm_cnt == {PWM_BITS{1'b1}});

    // A count above a freshly lowered PRESCALE restarts at 0 with no tick.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN || !r_en) begin
            r_pre_cnt     <= 16'd0;
            r_pwm_cnt     <= '0;
            r_blink_cnt   <= 16'd0;
            r_blink_phase <= 1'b1;
        end else begin
            if (r_pre_cnt >= r_prescale)
                r_pre_cnt <= 16'd0;
            else
                r_pre_cnt <= r_pre_cnt + 16'd1;
            if (w_tick)
                r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            if (w_boundary) begin
                if (r_blink_cnt >= r_half) begin
                    r_blink_cnt   <= 16'd0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 16'd1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
        logic [PWM_BITS-1:0] r_duty, r_sh_duty;
        logic [1:0]          r_mode, r_sh_mode;
        logic                r_led;
        logic                w_sel, w_raw;

        assign w_sel         = w_wr && (w_aw_idx == IDX_W'(gi + 2));
        assign w_raw         = (r_sh_duty == {PWM_BITS{1'b1}}) || (r_pwm_cnt < r_sh_duty);
        assign w_ch_word[gi] = 32'(r_duty) | (32'(r_mode) << 16);
        assign LED[gi]       = r_led;

        always_ff @(posedge ACLK or negedge ARESETN) begin
            if (!ARESETN) begin
                r_duty    <= '0;
                r_mode    <= 2'b00;
                r_sh_duty <= '0;
                r_sh_mode <= 2'b00;
                r_led     <= 1'b0;
            end else begin
                if (w_sel) begin
                    r_duty <= w_wr_word[PWM_BITS-1:0];
                    r_mode <= w_wr_word[17:16];
                end
                if (!r_en || w_boundary) begin
                    r_sh_duty <= r_duty;
                    r_sh_mode <= r_mode;
                end
                r_led <= r_en && (r_sh_mode != 2'b00) && w_raw
                         && ((r_sh_mode != 2'b10) || r_blink_phase);
            end
        end
    end
endmodule

// File: tb/tb_amdc_leds_pwm.sv
// Bench for amdc_leds_pwm: register access, PWM duty, shadowing, blink and AXI handshakes.
`timescale 1ns/1ps
module tb_amdc_leds_pwm;
    localparam int NL = 4;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [7:0]  S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0, S_AXI_ARPROT = '0;
    logic        S_AXI_AWVALID = 1'b0, S_AXI_WVALID = 1'b0, S_AXI_BREADY = 1'b0;
    logic        S_AXI_ARVALID = 1'b0, S_AXI_RREADY = 1'b0;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic [31:0] S_AXI_RDATA;
    logic [NL-1:0] LED;

    amdc_leds_pwm #(.NUM_LEDS(NL), .PWM_BITS(8), .C_S_AXI_ADDR_WIDTH(8), .C_S_AXI_DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY), .LED(LED)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hi_cnt   [NL] = '{default: 0};
    int rise_cnt [NL] = '{default: 0};
    logic [NL-1:0] led_prev = '0;
    logic [31:0] exp_q [$];

    always @(posedge ACLK) cyc++;

    // LED activity is accumulated on the falling edge, away from register updates.
    always @(negedge ACLK) begin
        for (int i = 0; i < NL; i++) begin
            if (LED[i]) hi_cnt[i]++;
            if (LED[i] && !led_prev[i]) rise_cnt[i]++;
        end
        led_prev = LED;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input string tag);
        int t;
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
        t = 0;
        tick();
        while (!S_AXI_AWREADY && t < 20) begin tick(); t++; end
        check({tag, "_awready"}, 32'(S_AXI_AWREADY & S_AXI_WREADY), 1);
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        t = 0;
        while (!S_AXI_BVALID && t < 20) begin tick(); t++; end
        check({tag, "_bresp"}, 32'({S_AXI_BVALID, S_AXI_BRESP}), 32'h4);
        tick();
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
        int t;
        exp_q.push_back(exp);
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        t = 0;
        tick();
        while (!S_AXI_ARREADY && t < 20) begin tick(); t++; end
        tick();
        S_AXI_ARVALID = 1'b0;
        t = 0;
        while (!S_AXI_RVALID && t < 20) begin tick(); t++; end
        check({tag, "_rresp"}, 32'({S_AXI_RVALID, S_AXI_RRESP}), 32'h4);
        check(tag, S_AXI_RDATA, exp_q.pop_front());
        tick();
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic sync_rise(input int ch, output int t0);
        logic prev;
        int t;
        prev = LED[ch];
        t = 0;
        while (t < 3000) begin
            tick(); t++;
            if (LED[ch] && !prev) break;
            prev = LED[ch];
        end
        check($sformatf("rise_led%0d", ch), 32'(t < 3000), 1);
        t0 = cyc;
    endtask

    task automatic window(input int ch, input int until_cyc, input int exp_hi, input string tag);
        int h0;
        h0 = hi_cnt[ch];
        while (cyc < until_cyc) tick();
        check(tag, 32'(hi_cnt[ch] - h0), 32'(exp_hi));
    endtask

    initial begin
        int t0, h0, r0, t;

        repeat (3) tick();
        check("reset_handshake", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY,
                                      S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP}), 0);
        check("reset_led_rdata", 32'(LED) | S_AXI_RDATA, 0);
        ARESETN = 1'b1;
        tick();

        for (int i = 0; i < 6; i++)
            axi_read(8'(4 * i), 32'h0, $sformatf("rst_rd_%02h", 4 * i));
        check("led_idle", 32'(LED), 0);

        for (int i = 0; i < NL; i++)
            axi_write(8'(8 + 4 * i), 32'h0001_0001 + 32'(i), 4'hF, $sformatf("wr_ch%0d", i));
        for (int i = 0; i < NL; i++)
            axi_read(8'(8 + 4 * i), 32'h0001_0001 + 32'(i), $sformatf("rd_ch%0d", i));

        // Duty 0x40 at PRESCALE 0, then a duty change written mid-period.
        axi_write(8'h08, 32'h0001_0040, 4'hF, "ch0_d40");
        axi_write(8'h00, 32'h0000_0001, 4'hF, "ctrl_en");
        sync_rise(0, t0);
        r0 = rise_cnt[0];
        window(0, t0 + 256, 64, "pwm_d40");
        h0 = hi_cnt[0];
        repeat (100) tick();
        axi_write(8'h08, 32'h0001_00C0, 4'hF, "ch0_dC0");
        while (cyc < t0 + 512) tick();
        check("shadow_cur_period", 32'(hi_cnt[0] - h0), 64);
        window(0, t0 + 768, 192, "shadow_next_period");
        check("no_glitch_rises", 32'(rise_cnt[0] - r0), 3);

        axi_write(8'h08, 32'h0001_00FF, 4'hF, "ch0_dFF");
        repeat (512) tick();
        window(0, cyc + 256, 256, "pwm_dFF_const_high");
        axi_write(8'h08, 32'h0001_0000, 4'hF, "ch0_d00");
        repeat (512) tick();
        window(0, cyc + 256, 0, "pwm_d00_const_low");
        axi_write(8'h08, 32'h0000_00FF, 4'hF, "ch0_mode00");
        repeat (512) tick();
        window(0, cyc + 256, 0, "mode00_off");
        axi_write(8'h08, 32'h0003_0040, 4'hF, "ch0_mode11");
        repeat (512) tick();
        window(0, cyc + 256, 64, "mode11_pwm");

        axi_write(8'h00, 32'h0001_0001, 4'hF, "ctrl_pre1");
        repeat (1100) tick();
        window(0, cyc + 512, 128, "prescale1_period");

        // Blink: half-period of two PWM periods, started from a fresh enable.
        axi_write(8'h00, 32'h0000_0000, 4'hF, "ctrl_dis");
        check("led_off_disabled", 32'(LED), 0);
        axi_write(8'h04, 32'h0000_0001, 4'hF, "blink_half1");
        axi_write(8'h0C, 32'h0002_00FF, 4'hF, "ch1_blink");
        axi_write(8'h00, 32'h0000_0001, 4'hF, "ctrl_en2");
        sync_rise(1, t0);
        window(1, t0 + 512, 512, "blink_high");
        window(1, t0 + 1024, 0, "blink_low");
        check("blink_high_again", 32'(LED[1]), 1);
        axi_write(8'h00, 32'h0000_0000, 4'hF, "ctrl_dis_mid");
        check("en_drop_led_off", 32'(LED), 0);

        axi_write(8'h10, 32'h0000_0000, 4'hF, "ch2_clr");
        axi_write(8'h10, 32'hFFFF_FFFF, 4'b0001, "ch2_strb0");
        axi_read(8'h10, 32'h0000_00FF, "rd_ch2_strb0");
        axi_write(8'h10, 32'hFFFF_FFFF, 4'b0100, "ch2_strb2");
        axi_read(8'h10, 32'h0003_00FF, "rd_ch2_strb2");

        axi_write(8'hFC, 32'hDEAD_BEEF, 4'hF, "wr_unmapped");
        axi_read(8'hFC, 32'h0, "rd_unmapped_fc");
        axi_read(8'h18, 32'h0, "rd_unmapped_18");
        axi_read(8'h14, 32'h0001_0004, "rd_ch3_intact");

        // Simultaneous read and write of BLINK returns the pre-write value.
        exp_q.push_back(32'h1);
        S_AXI_AWADDR = 8'h04; S_AXI_WDATA = 32'h5; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
        S_AXI_ARADDR = 8'h04; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        t = 0;
        tick();
        while (!S_AXI_AWREADY && t < 20) begin tick(); t++; end
        check("rw_ready_together", 32'({S_AXI_AWREADY, S_AXI_ARREADY}), 32'h3);
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        check("rw_both_valid", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'h3);
        check("rw_pre_write_data", S_AXI_RDATA, exp_q.pop_front());
        tick();
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        axi_read(8'h04, 32'h5, "rw_after");

        // Write response back-pressure with a second write already pending.
        S_AXI_AWADDR = 8'h04; S_AXI_WDATA = 32'h2; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        t = 0;
        tick();
        while (!S_AXI_AWREADY && t < 20) begin tick(); t++; end
        tick();
        S_AXI_AWADDR = 8'hFC;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_w_hold%0d", i), 32'({S_AXI_BVALID, S_AXI_AWREADY}), 32'h2);
        end
        S_AXI_BREADY = 1'b1;
        t = 0;
        tick();
        while (!S_AXI_AWREADY && t < 20) begin tick(); t++; end
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        check("bp_w_second_bvalid", 32'(S_AXI_BVALID), 1);
        tick();
        S_AXI_BREADY = 1'b0;

        // Read data back-pressure with a second read already pending.
        exp_q.push_back(32'h2);
        S_AXI_ARADDR = 8'h04; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        t = 0;
        tick();
        while (!S_AXI_ARREADY && t < 20) begin tick(); t++; end
        tick();
        S_AXI_ARADDR = 8'hFC;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_r_hold%0d", i), 32'({S_AXI_RVALID, S_AXI_ARREADY}), 32'h2);
        end
        check("bp_r_data", S_AXI_RDATA, exp_q.pop_front());
        exp_q.push_back(32'h0);
        S_AXI_RREADY = 1'b1;
        t = 0;
        tick();
        while (!S_AXI_ARREADY && t < 20) begin tick(); t++; end
        tick();
        S_AXI_ARVALID = 1'b0;
        check("bp_r_second", S_AXI_RDATA, exp_q.pop_front());
        tick();
        S_AXI_RREADY = 1'b0;

        // Reset while a read response is pending.
        axi_write(8'h00, 32'h0005_0000, 4'hF, "ctrl_pre5");
        S_AXI_ARADDR = 8'h00; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        t = 0;
        tick();
        while (!S_AXI_RVALID && t < 20) begin tick(); t++; end
        check("mr_rdata_before", S_AXI_RDATA, 32'h0005_0000);
        ARESETN = 1'b0;
        #1;
        check("mr_handshake_dropped", 32'({S_AXI_ARREADY, S_AXI_RVALID, S_AXI_AWREADY,
                                           S_AXI_BVALID}), 0);
        S_AXI_ARVALID = 1'b0;
        tick();
        ARESETN = 1'b1;
        tick();
        axi_read(8'h00, 32'h0, "mr_ctrl_cleared");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
